// File: rtl/ahb_pkg.sv
// Shared AHB encodings: transfer types, response codes and the slave data-path states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int unsigned HSPLIT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StResp1,
    StResp2
  } dp_state_e;

endpackage

// File: rtl/ahb_split_tracker.sv
// Tracks the single outstanding SPLIT: owner, release countdown and the hsplit pulse.
module ahb_split_tracker
  import ahb_pkg::*;
#(
  parameter int unsigned SPLIT_LATENCY = 8
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                split_req,
  input  logic [1:0]          split_master,
  input  logic                split_done,
  output logic                pending,
  output logic                released,
  output logic [1:0]          rec_master,
  output logic [HSPLIT_W-1:0] hsplit
);

  typedef enum logic [1:0] {
    TrNone,
    TrCount,
    TrReleased
  } tr_state_e;

  localparam logic [7:0] CntInit = 8'(SPLIT_LATENCY);

  tr_state_e             state_q;
  logic [7:0]            cnt_q;
  logic [1:0]            rec_master_q;
  logic [HSPLIT_W-1:0]   hsplit_q;

  // Countdown starts at the SPLIT address phase so the pulse lands
  // SPLIT_LATENCY + 2 cycles after it; hsplit is high for one cycle only.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q      <= TrNone;
      cnt_q        <= '0;
      rec_master_q <= '0;
      hsplit_q     <= '0;
    end else begin
      hsplit_q <= '0;
      unique case (state_q)
        TrNone: begin
          if (split_req) begin
            state_q      <= TrCount;
            rec_master_q <= split_master;
            cnt_q        <= CntInit;
          end
        end
        TrCount: begin
          if (cnt_q == '0) begin
            state_q  <= TrReleased;
            hsplit_q <= HSPLIT_W'(1) << rec_master_q;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        TrReleased: begin
          if (split_done) begin
            state_q <= TrNone;
          end
        end
        default: state_q <= TrNone;
      endcase
    end
  end

  assign pending    = (state_q != TrNone);
  assign released   = (state_q == TrReleased);
  assign rec_master = rec_master_q;
  assign hsplit     = hsplit_q;

endmodule

// File: rtl/ahb_split_slave.sv
// AHB slave: word memory, read wait states and two-cycle ERROR/RETRY/SPLIT responses.
module ahb_split_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_WORDS     = 16,
  parameter int unsigned WAIT_STATES   = 1,
  parameter int unsigned SPLIT_LATENCY = 8,
  parameter int unsigned SLOW_BIT      = 10
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                hsel,
  input  logic [31:0]         haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [31:0]         hwdata,
  input  logic [1:0]          hmaster,
  input  logic                hready_in,
  output logic [31:0]         hrdata,
  output logic                hready,
  output logic [1:0]          hresp,
  output logic [HSPLIT_W-1:0] hsplit
);

  localparam int unsigned IdxW     = $clog2(MEM_WORDS);
  localparam logic [2:0]  WaitInit = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  dp_state_e        state_q;
  logic             hready_q;
  logic [1:0]       hresp_q;
  logic [31:0]      hrdata_q;
  logic [2:0]       wait_cnt_q;
  logic [IdxW-1:0]  rd_idx_q;
  logic             wr_pend_q;
  logic [IdxW-1:0]  wr_idx_q;
  logic [31:0]      mem_q [MEM_WORDS];

  logic             acc;
  logic [IdxW-1:0]  idx;
  logic             bad;
  logic [1:0]       code;
  logic             split_req;
  logic             split_done;
  logic             pending;
  logic             released;
  logic [1:0]       rec_master;
  logic [31:0]      fwd_data;
  logic             unused_bits;

  // New address phases are only taken while our data phase is ready.
  assign acc = hsel && hready_in && htrans[1] && ((state_q == StIdle) || (state_q == StResp2));
  assign idx = haddr[IdxW+1:2];
  // A zero-wait read can coincide with the previous write's data phase.
  assign fwd_data = (wr_pend_q && (wr_idx_q == idx)) ? hwdata : mem_q[idx];
  assign unused_bits = ^{haddr, htrans[0]};

  // Classify the presented address phase in priority order.
  always_comb begin
    bad        = 1'b0;
    code       = HRESP_OKAY;
    split_req  = 1'b0;
    split_done = 1'b0;
    if (haddr[1:0] != 2'b00) begin
      bad  = 1'b1;
      code = HRESP_ERROR;
    end else if (haddr[SLOW_BIT]) begin
      if (!pending) begin
        bad       = 1'b1;
        code      = HRESP_SPLIT;
        split_req = acc;
      end else if ((hmaster != rec_master) || !released) begin
        bad  = 1'b1;
        code = HRESP_RETRY;
      end else begin
        split_done = acc;
      end
    end
  end

  // Data-path FSM, memory and registered bus outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= StIdle;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
      hrdata_q   <= '0;
      wait_cnt_q <= '0;
      rd_idx_q   <= '0;
      wr_pend_q  <= 1'b0;
      wr_idx_q   <= '0;
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_pend_q) begin
        mem_q[wr_idx_q] <= hwdata;
      end
      wr_pend_q <= 1'b0;
      unique case (state_q)
        StRdWait: begin
          if (wait_cnt_q == '0) begin
            hready_q <= 1'b1;
            hrdata_q <= mem_q[rd_idx_q];
            state_q  <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        StResp1: begin
          hready_q <= 1'b1;
          state_q  <= StResp2;
        end
        StIdle, StResp2: begin
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
          state_q  <= StIdle;
          if (acc) begin
            if (bad) begin
              hready_q <= 1'b0;
              hresp_q  <= code;
              state_q  <= StResp1;
            end else if (hwrite) begin
              wr_pend_q <= 1'b1;
              wr_idx_q  <= idx;
            end else if (WAIT_STATES == 0) begin
              hrdata_q <= fwd_data;
            end else begin
              hready_q   <= 1'b0;
              wait_cnt_q <= WaitInit;
              rd_idx_q   <= idx;
              state_q    <= StRdWait;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  ahb_split_tracker #(
    .SPLIT_LATENCY(SPLIT_LATENCY)
  ) u_tracker (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .split_req   (split_req),
    .split_master(hmaster),
    .split_done  (split_done),
    .pending     (pending),
    .released    (released),
    .rec_master  (rec_master),
    .hsplit      (hsplit)
  );

  assign hready = hready_q;
  assign hresp  = hresp_q;
  assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_split_slave.sv
// Directed bench for ahb_split_slave with default parameters (WAIT_STATES 1, SPLIT_LATENCY 8).
module tb_ahb_split_slave;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [1:0]  hmaster;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [15:0] hsplit;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sa;
  int pcyc;
  int npulse;
  logic [15:0] pval;

  // Single slave on the bus: the bus hready is this slave's hready.
  assign hready_in = hready;

  always #5 hclk = ~hclk;

  ahb_split_slave dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hsel     (hsel),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hwdata   (hwdata),
    .hmaster  (hmaster),
    .hready_in(hready_in),
    .hrdata   (hrdata),
    .hready   (hready),
    .hresp    (hresp),
    .hsplit   (hsplit)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One address phase; returns in the first data-phase cycle with htrans back to IDLE.
  task automatic addr(input logic [31:0] a, input logic w, input logic [1:0] m);
    hsel    = 1'b1;
    haddr   = a;
    htrans  = HTRANS_NONSEQ;
    hwrite  = w;
    hmaster = m;
    tick();
    htrans = HTRANS_IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    hresetn = 1'b0;
    hsel    = 1'b0;
    haddr   = '0;
    htrans  = HTRANS_IDLE;
    hwrite  = 1'b0;
    hwdata  = '0;
    hmaster = '0;
    tick();
    tick();
    chk("rst_hready", 32'(hready), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'(HRESP_OKAY));
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_hsplit", 32'(hsplit), 32'h0);
    hresetn = 1'b1;
    tick();

    // Write then pipelined read of the same word.
    addr(32'h4, 1'b1, 2'd0);
    hwdata = 32'hDEADBEEF;
    chk("wr_hready", 32'(hready), 32'd1);
    chk("wr_hresp", 32'(hresp), 32'(HRESP_OKAY));
    addr(32'h4, 1'b0, 2'd0);
    chk("rd_wait_hready", 32'(hready), 32'd0);
    tick();
    chk("rd_hready", 32'(hready), 32'd1);
    chk("rd_hresp", 32'(hresp), 32'(HRESP_OKAY));
    chk("rd_data", hrdata, 32'hDEADBEEF);
    tick();

    // Unaligned write and read give ERROR and leave memory alone.
    addr(32'h5, 1'b1, 2'd0);
    hwdata = 32'h12345678;
    chk("err1_hready", 32'(hready), 32'd0);
    chk("err1_hresp", 32'(hresp), 32'(HRESP_ERROR));
    tick();
    chk("err2_hready", 32'(hready), 32'd1);
    chk("err2_hresp", 32'(hresp), 32'(HRESP_ERROR));
    chk("err_hrdata_hold", hrdata, 32'hDEADBEEF);
    tick();
    chk("err_done_hresp", 32'(hresp), 32'(HRESP_OKAY));
    addr(32'h6, 1'b0, 2'd0);
    chk("erd1_hready", 32'(hready), 32'd0);
    chk("erd1_hresp", 32'(hresp), 32'(HRESP_ERROR));
    tick();
    chk("erd2_hready", 32'(hready), 32'd1);
    chk("erd2_hresp", 32'(hresp), 32'(HRESP_ERROR));
    tick();
    addr(32'h4, 1'b0, 2'd0);
    tick();
    chk("err_mem_intact", hrdata, 32'hDEADBEEF);

    // BUSY and unselected transfers do nothing.
    hsel   = 1'b1;
    haddr  = 32'h4;
    htrans = HTRANS_BUSY;
    hwrite = 1'b1;
    tick();
    hwdata = 32'h11111111;
    chk("busy_hready", 32'(hready), 32'd1);
    chk("busy_hresp", 32'(hresp), 32'(HRESP_OKAY));
    hsel   = 1'b0;
    htrans = HTRANS_NONSEQ;
    tick();
    hwdata = 32'h22222222;
    chk("unsel_hready", 32'(hready), 32'd1);
    chk("unsel_hresp", 32'(hresp), 32'(HRESP_OKAY));
    hsel   = 1'b1;
    htrans = HTRANS_IDLE;
    tick();
    addr(32'h4, 1'b0, 2'd0);
    tick();
    chk("idle_mem_intact", hrdata, 32'hDEADBEEF);

    // Word 0 aliases with the slow address 0x400.
    addr(32'h0, 1'b1, 2'd0);
    hwdata = 32'hCAFEF00D;
    tick();

    // Master 2 hits the slow region and is split.
    sa = cyc;
    addr(32'h400, 1'b0, 2'd2);
    chk("split1_hready", 32'(hready), 32'd0);
    chk("split1_hresp", 32'(hresp), 32'(HRESP_SPLIT));
    tick();
    chk("split2_hready", 32'(hready), 32'd1);
    chk("split2_hresp", 32'(hresp), 32'(HRESP_SPLIT));
    tick();

    // Master 1 is retried while master 2 is pending.
    addr(32'h404, 1'b0, 2'd1);
    chk("retry1_hready", 32'(hready), 32'd0);
    chk("retry1_hresp", 32'(hresp), 32'(HRESP_RETRY));
    chk("retry1_hsplit", 32'(hsplit), 32'h0);
    tick();
    chk("retry2_hready", 32'(hready), 32'd1);
    chk("retry2_hresp", 32'(hresp), 32'(HRESP_RETRY));
    chk("retry2_hsplit", 32'(hsplit), 32'h0);
    tick();

    npulse = 0;
    pcyc   = 0;
    pval   = '0;
    for (int i = 0; i < 30; i++) begin
      if (hsplit != '0) begin
        if (npulse == 0) begin
          pcyc = cyc;
          pval = hsplit;
        end
        npulse++;
      end
      tick();
    end
    chk("hsplit_pulse_count", 32'(npulse), 32'd1);
    chk("hsplit_pulse_time", 32'(pcyc - sa), 32'd10);
    chk("hsplit_pulse_mask", 32'(pval), 32'h0004);

    // Released but master 1 is not the owner: still RETRY.
    addr(32'h404, 1'b0, 2'd1);
    chk("rel_retry_hresp", 32'(hresp), 32'(HRESP_RETRY));
    tick();
    tick();

    // Owner returns and completes normally.
    addr(32'h400, 1'b0, 2'd2);
    chk("own_wait_hready", 32'(hready), 32'd0);
    chk("own_wait_hresp", 32'(hresp), 32'(HRESP_OKAY));
    tick();
    chk("own_hready", 32'(hready), 32'd1);
    chk("own_data", hrdata, 32'hCAFEF00D);
    tick();

    // Pending cleared, so master 1 is now split.
    addr(32'h404, 1'b0, 2'd1);
    chk("m1_split_hready", 32'(hready), 32'd0);
    chk("m1_split_hresp", 32'(hresp), 32'(HRESP_SPLIT));
    tick();
    tick();
    tick();

    // Reset in the middle of the countdown drops the split.
    hresetn = 1'b0;
    #1;
    chk("mid_rst_hready", 32'(hready), 32'd1);
    chk("mid_rst_hresp", 32'(hresp), 32'(HRESP_OKAY));
    chk("mid_rst_hrdata", hrdata, 32'h0);
    chk("mid_rst_hsplit", 32'(hsplit), 32'h0);
    tick();
    tick();
    hresetn = 1'b1;
    npulse  = 0;
    for (int i = 0; i < 20; i++) begin
      if (hsplit != '0) npulse++;
      tick();
    end
    chk("post_rst_no_pulse", 32'(npulse), 32'd0);
    addr(32'h4, 1'b0, 2'd0);
    tick();
    chk("post_rst_hready", 32'(hready), 32'd1);
    chk("post_rst_mem", hrdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
